// File: rtl/emu_reset_seq.sv
// rtl/emu_reset_seq.sv - staggered multi-channel emulation reset sequencer
// Optional RESET_SEQ_CFG_EN adds the cfg_hold runtime hold override port.
module emu_reset_seq #(
  parameter int CHANNELS       = 4,
  parameter int CNT_WIDTH      = 16,
  parameter int HOLD_CYCLES    = 20,
  parameter int STAGGER_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 trig_valid,
  output logic                 trig_ready,
  output logic [CHANNELS-1:0]  reset_out,
  output logic                 busy,
  output logic                 done
`ifdef RESET_SEQ_CFG_EN
  ,
  input  logic [CNT_WIDTH-1:0] cfg_hold
`endif
);

  if (CHANNELS < 1 || CHANNELS > 32) begin : g_bad_channels
    $error("emu_reset_seq: CHANNELS must be in 1..32");
  end
  if (longint'(HOLD_CYCLES) >= (longint'(1) << CNT_WIDTH)) begin : g_bad_hold
    $error("emu_reset_seq: HOLD_CYCLES does not fit in CNT_WIDTH");
  end
  if (longint'(STAGGER_CYCLES) >= (longint'(1) << CNT_WIDTH)) begin : g_bad_stagger
    $error("emu_reset_seq: STAGGER_CYCLES does not fit in CNT_WIDTH");
  end

  localparam int IDX_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic [IDX_W-1:0] LAST_CH = IDX_W'(CHANNELS - 1);
  localparam logic [CNT_WIDTH-1:0] STAG_LAST =
    (STAGGER_CYCLES > 0) ? CNT_WIDTH'(STAGGER_CYCLES - 1) : '0;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  // With no stagger (or a single channel) every channel drops on the hold-expiry edge.
  localparam bit ALL_AT_ONCE = (STAGGER_CYCLES == 0) || (CHANNELS == 1);

  typedef enum logic [1:0] {
    S_ASSERT  = 2'd0,
    S_RELEASE = 2'd1,
    S_IDLE    = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [CNT_WIDTH-1:0]   hold_cnt_q, hold_cnt_d;
  logic [CNT_WIDTH-1:0]   stag_cnt_q, stag_cnt_d;
  logic [IDX_W-1:0]       chan_q, chan_d;
  logic [CNT_WIDTH-1:0]   hold_q, hold_d;
  logic [CHANNELS-1:0]    reset_out_q, reset_out_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   trig_ready_q, trig_ready_d;

  logic [CNT_WIDTH-1:0]   hold_src;
  logic [CNT_WIDTH-1:0]   hold_eff;

`ifdef RESET_SEQ_CFG_EN
  assign hold_src = cfg_hold;
`else
  assign hold_src = CNT_WIDTH'(HOLD_CYCLES);
`endif
  assign hold_eff = (hold_src == '0) ? CNT_WIDTH'(1) : hold_src;

  always_comb begin
    state_d      = state_q;
    hold_cnt_d   = hold_cnt_q;
    stag_cnt_d   = stag_cnt_q;
    chan_d       = chan_q;
    hold_d       = hold_q;
    reset_out_d  = reset_out_q;
    busy_d       = busy_q;
    done_d       = done_q;
    trig_ready_d = trig_ready_q;

    case (state_q)
      S_ASSERT: begin
        if (hold_cnt_q >= hold_q - CNT_WIDTH'(1)) begin
          if (ALL_AT_ONCE) begin
            reset_out_d  = '0;
            state_d      = S_IDLE;
            busy_d       = 1'b0;
            done_d       = 1'b1;
            trig_ready_d = 1'b1;
          end else begin
            reset_out_d = reset_out_q & ~CHANNELS'(1);
            chan_d      = IDX_W'(1);
            stag_cnt_d  = '0;
            state_d     = S_RELEASE;
          end
        end else if (hold_cnt_q != CNT_MAX) begin
          hold_cnt_d = hold_cnt_q + CNT_WIDTH'(1);
        end
      end

      S_RELEASE: begin
        if (stag_cnt_q >= STAG_LAST) begin
          reset_out_d = reset_out_q & ~(CHANNELS'(1) << chan_q);
          stag_cnt_d  = '0;
          if (chan_q >= LAST_CH) begin
            state_d      = S_IDLE;
            busy_d       = 1'b0;
            done_d       = 1'b1;
            trig_ready_d = 1'b1;
          end else begin
            chan_d = chan_q + IDX_W'(1);
          end
        end else if (stag_cnt_q != CNT_MAX) begin
          stag_cnt_d = stag_cnt_q + CNT_WIDTH'(1);
        end
      end

      S_IDLE: begin
        if (trig_valid && trig_ready_q) begin
          state_d      = S_ASSERT;
          hold_cnt_d   = '0;
          stag_cnt_d   = '0;
          chan_d       = '0;
          hold_d       = hold_eff;
          reset_out_d  = '1;
          busy_d       = 1'b1;
          done_d       = 1'b0;
          trig_ready_d = 1'b0;
        end
      end

      default: begin
        state_d = S_ASSERT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_ASSERT;
      hold_cnt_q   <= '0;
      stag_cnt_q   <= '0;
      chan_q       <= '0;
      hold_q       <= hold_eff;
      reset_out_q  <= '1;
      busy_q       <= 1'b1;
      done_q       <= 1'b0;
      trig_ready_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_cnt_q   <= hold_cnt_d;
      stag_cnt_q   <= stag_cnt_d;
      chan_q       <= chan_d;
      hold_q       <= hold_d;
      reset_out_q  <= reset_out_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      trig_ready_q <= trig_ready_d;
    end
  end

  assign reset_out  = reset_out_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign trig_ready = trig_ready_q;

endmodule

// File: tb/tb_emu_reset_seq.sv
// tb/tb_emu_reset_seq.sv - scoreboard bench for emu_reset_seq (default and zero-hold/zero-stagger)
module tb_emu_reset_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       trig_valid;
  logic       trig_ready_a, busy_a, done_a;
  logic       trig_ready_z, busy_z, done_z;
  logic [3:0] reset_out_a, reset_out_z;
`ifdef RESET_SEQ_CFG_EN
  logic [15:0] cfg_hold;
`endif

  always #5 clk = ~clk;

  emu_reset_seq u_dut_a (
    .clk        (clk),
    .rst        (rst),
    .trig_valid (trig_valid),
    .trig_ready (trig_ready_a),
    .reset_out  (reset_out_a),
    .busy       (busy_a),
    .done       (done_a)
`ifdef RESET_SEQ_CFG_EN
    ,
    .cfg_hold   (cfg_hold)
`endif
  );

  emu_reset_seq #(
    .HOLD_CYCLES    (0),
    .STAGGER_CYCLES (0)
  ) u_dut_z (
    .clk        (clk),
    .rst        (rst),
    .trig_valid (trig_valid),
    .trig_ready (trig_ready_z),
    .reset_out  (reset_out_z),
    .busy       (busy_z),
    .done       (done_z)
`ifdef RESET_SEQ_CFG_EN
    ,
    .cfg_hold   (cfg_hold)
`endif
  );

  typedef struct packed {
    logic [3:0] ro;
    logic       busy;
    logic       done;
    logic       ready;
  } obs_t;

  typedef struct packed {
    obs_t a;
    obs_t z;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc   = 0;

  // Reference: edges since sequence start, compared against H + k*S per channel.
  int   n_a = 0, n_z = 0;
  int   h_a = 20, h_z = 1;
  bit   idle_a = 1'b0, idle_z = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  function automatic obs_t predict(input int n, input int h, input int s);
    obs_t o;
    for (int k = 0; k < 4; k++) o.ro[k] = (n < h + k * s);
    o.done  = (n >= h + 3 * s);
    o.busy  = ~o.done;
    o.ready = o.done;
    return o;
  endfunction

  function automatic int hold_of(input int src);
    return (src == 0) ? 1 : src;
  endfunction

  task automatic step(input bit r, input bit t);
    exp_t e;
    exp_t got;
    @(negedge clk);
    rst        = r;
    trig_valid = t;
    if (r || (idle_a && t)) begin
      n_a = 0;
`ifdef RESET_SEQ_CFG_EN
      h_a = hold_of(int'(cfg_hold));
`else
      h_a = hold_of(20);
`endif
    end else if (n_a < 100000) begin
      n_a++;
    end
    if (r || (idle_z && t)) begin
      n_z = 0;
`ifdef RESET_SEQ_CFG_EN
      h_z = hold_of(int'(cfg_hold));
`else
      h_z = hold_of(0);
`endif
    end else if (n_z < 100000) begin
      n_z++;
    end
    e.a = predict(n_a, h_a, 4);
    e.z = predict(n_z, h_z, 0);
    idle_a = e.a.done;
    idle_z = e.z.done;
    exp_q.push_back(e);

    @(posedge clk);
    #1;
    cyc++;
    got = exp_q.pop_front();
    check("a.reset_out",  32'(reset_out_a),  32'(got.a.ro));
    check("a.busy",       32'(busy_a),       32'(got.a.busy));
    check("a.done",       32'(done_a),       32'(got.a.done));
    check("a.trig_ready", 32'(trig_ready_a), 32'(got.a.ready));
    check("z.reset_out",  32'(reset_out_z),  32'(got.z.ro));
    check("z.busy",       32'(busy_z),       32'(got.z.busy));
    check("z.done",       32'(done_z),       32'(got.z.done));
    check("z.trig_ready", 32'(trig_ready_z), 32'(got.z.ready));
  endtask

  initial begin
    rst        = 1'b1;
    trig_valid = 1'b0;
`ifdef RESET_SEQ_CFG_EN
    cfg_hold   = 16'd20;
`endif

    // Power-on reset then full release pattern.
    repeat (3) step(1'b1, 1'b0);
    repeat (36) step(1'b0, 1'b0);

    // Single-cycle trigger from IDLE.
    step(1'b0, 1'b1);
    repeat (40) step(1'b0, 1'b0);

    // Trigger held high across a whole sequence and beyond.
    repeat (80) step(1'b0, 1'b1);
    repeat (40) step(1'b0, 1'b0);

    // rst one cycle at edge 26 after acceptance.
    step(1'b0, 1'b1);
    repeat (25) step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    repeat (40) step(1'b0, 1'b0);

`ifdef RESET_SEQ_CFG_EN
    cfg_hold = 16'd5;
    step(1'b1, 1'b0);
    repeat (3) step(1'b0, 1'b0);
    cfg_hold = 16'd50;
    repeat (20) step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    repeat (70) step(1'b0, 1'b0);
    cfg_hold = 16'd0;
    step(1'b0, 1'b1);
    repeat (20) step(1'b0, 1'b0);
    cfg_hold = 16'd20;
`endif

    // Random triggers with occasional mid-sequence rst.
    repeat (200) step($urandom_range(0, 40) == 0, $urandom_range(0, 9) == 0);
    repeat (40) step(1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
